// File: rtl/mips.sv
// Single-cycle MIPS core: add, sub, and, or, slt, lw, sw, beq, addi, j.
// Combinational decode with a PC register and a 32x32 register file; one instruction retires per clock.
module mips (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        memwrite,
  output logic [31:0] aluout,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_J     = 6'b000010
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NONE
  } alu_ctl_e;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic        regwrite;
  logic        regdst;
  logic        alusrc;
  logic        branch;
  logic        memtoreg;
  logic        jump;
  logic [1:0]  aluop;
  alu_ctl_e    alu_ctl;

  logic [31:0] pc_next;
  logic [31:0] pcplus4;
  logic [31:0] pcbranch;
  logic [31:0] signimm;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] result;
  logic [4:0]  write_reg;
  logic        zero;

  logic [31:0] rf [32];

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];

  // Main decoder; opcodes outside the subset fall through as no-ops.
  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    regwrite = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    jump     = 1'b0;
    aluop    = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        aluop    = 2'b10;
      end
      OP_LW: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      OP_SW: begin
        alusrc   = 1'b1;
        memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch   = 1'b1;
        aluop    = 2'b01;
      end
      OP_ADDI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OP_J: jump = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_NONE;
    case (aluop)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      default: begin
        case (funct)
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_NONE;
        endcase
      end
    endcase
  end

  assign signimm   = {{16{instr[15]}}, instr[15:0]};
  assign srca      = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign writedata = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign srcb      = alusrc ? signimm : writedata;

  always_comb begin
    result = 32'd0;
    case (alu_ctl)
      ALU_ADD: result = srca + srcb;
      ALU_SUB: result = srca - srcb;
      ALU_AND: result = srca & srcb;
      ALU_OR:  result = srca | srcb;
      ALU_SLT: result = {31'd0, $signed(srca) < $signed(srcb)};
      default: result = 32'd0;
    endcase
  end

  assign aluout = result;
  assign zero   = (result == 32'd0);

  assign pcplus4  = pc + 32'd4;
  assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};

  always_comb begin
    pc_next = pcplus4;
    if (jump)
      pc_next = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      pc_next = pcbranch;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'd0;
    else        pc <= pc_next;
  end

  assign write_reg = regdst ? rd : rt;

  // NOTE: the register file is deliberately left out of reset; it maps onto plain RAM and software initialises it.
  always_ff @(posedge clk) begin
    if (regwrite && (write_reg != 5'd0))
      rf[write_reg] <= memtoreg ? readdata : result;
  end

endmodule

// File: tb/tb_mips.sv
// Directed bench for the single-cycle MIPS core; instructions and load data are driven straight onto the ports.
module tb_mips;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int checks;
  int failures;

  localparam logic [31:0] NOP = 32'h0000_0020;

  mips dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .instr    (instr),
    .memwrite (memwrite),
    .aluout   (aluout),
    .writedata(writedata),
    .readdata (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction and let the combinational paths settle.
  task automatic issue(input logic [31:0] v);
    instr = v;
    #2;
  endtask

  // Commit the current instruction on the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [31:0] v);
    issue(v);
    tick();
  endtask

  // Pulse reset between edges and leave pc at 0 ready for the next issue.
  task automatic do_reset();
    @(negedge clk);
    instr = NOP;
    reset = 1'b0;
    #1;
    check("reset_pc_immediate", pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    instr    = NOP;
    readdata = 32'd0;

    #2;
    check("pc_in_reset", pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("pc_after_release", pc, 32'd0);
    exec(NOP);
    check("pc_step_4", pc, 32'd4);
    exec(NOP);
    check("pc_step_8", pc, 32'd8);

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("pc_async_reset", pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ALU and store
    exec(32'h2002_0005);                   // addi $2,$0,5
    exec(32'h2003_000C);                   // addi $3,$0,12
    issue(32'h0043_2020);                  // add $4,$2,$3
    check("add_aluout", aluout, 32'd17);
    check("add_memwrite", {31'd0, memwrite}, 32'd0);
    tick();
    issue(32'hAC04_0054);                  // sw $4,84($0)
    check("sw_memwrite", {31'd0, memwrite}, 32'd1);
    check("sw_aluout", aluout, 32'd84);
    check("sw_writedata", writedata, 32'd17);
    tick();

    // Logic ops on 5 and 12
    issue(32'h0043_2825);                  // or $5,$2,$3
    check("or_aluout", aluout, 32'd13);
    tick();
    issue(32'h0043_3024);                  // and $6,$2,$3
    check("and_aluout", aluout, 32'd4);
    tick();
    issue(32'hAC05_0000);                  // sw $5,0($0)
    check("or_written", writedata, 32'd13);
    tick();

    // Signed slt with a negative operand
    exec(32'h2003_FFFF);                   // addi $3,$0,-1
    issue(32'h0062_202A);                  // slt $4,$3,$2  (-1 < 5)
    check("slt_true_aluout", aluout, 32'd1);
    tick();
    issue(32'hAC04_0000);                  // sw $4,0($0)
    check("slt_sw_writedata", writedata, 32'd1);
    tick();
    issue(32'h0043_202A);                  // slt $4,$2,$3  (5 < -1 false)
    check("slt_false_aluout", aluout, 32'd0);
    tick();
    issue(32'h0043_3822);                  // sub $7,$2,$3  (5 - -1)
    check("sub_aluout", aluout, 32'd6);
    tick();

    // Load
    readdata = 32'hDEAD_BEEF;
    issue(32'h8C05_0050);                  // lw $5,80($0)
    check("lw_aluout", aluout, 32'd80);
    check("lw_memwrite", {31'd0, memwrite}, 32'd0);
    tick();
    readdata = 32'd0;
    issue(32'hAC05_0004);                  // sw $5,4($0)
    check("lw_sw_writedata", writedata, 32'hDEAD_BEEF);
    check("lw_sw_aluout", aluout, 32'd4);
    tick();

    // Write to $0 is discarded
    exec(32'h2000_0007);                   // addi $0,$0,7
    issue(32'hAC00_0008);                  // sw $0,8($0)
    check("r0_writedata", writedata, 32'd0);
    tick();

    // Unsupported opcode is a no-op: no register write, pc+4
    issue(32'h3402_00FF);                  // ori $2,$0,0xFF
    check("nop_op_memwrite", {31'd0, memwrite}, 32'd0);
    tick();
    issue(32'hAC02_0000);                  // sw $2,0($0)
    check("nop_op_no_write", writedata, 32'd5);
    tick();

    // Unsupported funct: result 0 but rd is still written
    exec(32'h2008_0009);                   // addi $8,$0,9
    issue(32'h0043_4000);                  // funct 000000, rd=$8
    check("bad_funct_aluout", aluout, 32'd0);
    tick();
    issue(32'hAC08_0000);                  // sw $8,0($0)
    check("bad_funct_written", writedata, 32'd0);
    tick();

    // Taken branch from pc 0x10; registers survive reset
    do_reset();
    issue(32'hAC02_0000);                  // sw $2,0($0)
    check("rf_kept_over_reset", writedata, 32'd5);
    tick();
    exec(NOP);
    exec(NOP);
    exec(NOP);
    check("pc_at_0x10", pc, 32'h10);
    exec(32'h1042_0003);                   // beq $2,$2,3
    check("beq_taken_pc", pc, 32'h20);

    // Not-taken branch, then jump
    do_reset();
    exec(NOP);
    exec(NOP);
    exec(NOP);
    exec(NOP);
    exec(32'h1043_0003);                   // beq $2,$3,3 (5 != -1)
    check("beq_not_taken_pc", pc, 32'h14);
    exec(32'h0800_0011);                   // j 0x11
    check("j_pc", pc, 32'h44);
    exec(32'h1000_FFFF);                   // beq $0,$0,-1
    check("beq_backward_pc", pc, 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
